dispatch_credit_arbiter: RTL and testbench

DISPATCH_CREDIT_ARBITER -- requirements
Module: dispatch_credit_arbiter

---
 rtl/dispatch_credit_arbiter.sv | 151 +++++++++++++++
 tb/tb_dispatch_credit_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_credit_arbiter.sv
// dispatch_credit_arbiter
//   Maps the in-order dispatch slots onto the integer issue queues. Each IQ
//   has one write port and a credit counter of free entries. Slots are granted
//   oldest-first to IQs that have credit, visiting the IQs round-robin. A
//   redirect kills all grants and enters FLUSH. FLUSH ends once every IQ
//   reports empty, and all credits are then refilled.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid        per-slot op present (slot 0 oldest)
//   iq_release      entries freed by each IQ this cycle
//   iq_empty        IQ holds no valid entry
//   redirect        backend flush request
//   grant/grant_iq  slot accepted / target IQ (combinational)
//   stall           some valid slot not granted (combinational)
//   credit          registered free-entry count per IQ
//   busy            registered, high in FLUSH
//   overflow_err    sticky credit-overflow flag

// Per-IQ credit counter
module dispatch_credit_arbiter_iq #(
   parameter int IQ_DEPTH = 8,
   parameter int CW       = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,     // state is RUN; releases are ignored otherwise
   input  logic          reload,  // FLUSH -> RUN: IQs are empty again
   input  logic          alloc,
   input  logic [CW-1:0] rel,
   output logic [CW-1:0] credit,
   output logic          ovf
);
   logic [CW:0] sum;

   // One extra bit, so a release beyond the free space is seen rather than wrapped
   always_comb begin
      sum = {1'b0, credit} - {{CW{1'b0}}, alloc} + {1'b0, rel};
      ovf = run && (sum > (CW+1)'(IQ_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst || reload) credit <= CW'(IQ_DEPTH);
      else if (run)      credit <= ovf ? CW'(IQ_DEPTH) : sum[CW-1:0];
   end
endmodule

module dispatch_credit_arbiter #(
   parameter  int IN_WIDTH = 4,
   parameter  int NUM_IQ   = 2,
   parameter  int IQ_DEPTH = 8,
   localparam int CW       = $clog2(IQ_DEPTH+1),
   localparam int IW       = (NUM_IQ > 1) ? $clog2(NUM_IQ) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [IN_WIDTH-1:0]            in_valid,
   input  logic [NUM_IQ-1:0][CW-1:0]      iq_release,
   input  logic [NUM_IQ-1:0]              iq_empty,
   input  logic                           redirect,
   output logic [IN_WIDTH-1:0]            grant,
   output logic [IN_WIDTH-1:0][IW-1:0]    grant_iq,
   output logic                           stall,
   output logic [NUM_IQ-1:0][CW-1:0]      credit,
   output logic                           busy,
   output logic                           overflow_err
);
   typedef enum logic {RUN, FLUSH} state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     rr_ptr, rr_nxt;
   logic [NUM_IQ-1:0] alloc, ovf;
   logic              reload, run, kill;

   assign run  = (state == RUN);
   assign busy = (state == FLUSH);
   assign kill = (state == FLUSH) || redirect;

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      reload    = 1'b0;
      case (state)
         RUN:   if (redirect) state_nxt = FLUSH;
         FLUSH: if (!redirect && (&iq_empty)) begin
            state_nxt = RUN;
            reload    = 1'b1;
         end
         default: state_nxt = RUN;
      endcase
   end

   // Walk the IQs once in rotation from rr_ptr. Each IQ with credit takes the
   // oldest slot still waiting. The first invalid slot (or running out of
   // slots) ends the walk, so grants are always a prefix of the slots.
   always_comb begin
      int   slot;
      int   idx;
      logic blocked;
      grant    = '0;
      grant_iq = '0;
      alloc    = '0;
      rr_nxt   = rr_ptr;
      slot     = 0;
      idx      = 0;
      blocked  = kill;
      for (int k = 0; k < NUM_IQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_IQ) idx = idx - NUM_IQ;
         if (!blocked && (credit[idx] != '0)) begin
            if (slot >= IN_WIDTH)     blocked = 1'b1;
            else if (!in_valid[slot]) blocked = 1'b1;
            else begin
               grant[slot]    = 1'b1;
               grant_iq[slot] = IW'(idx);
               alloc[idx]     = 1'b1;
               rr_nxt         = (idx == NUM_IQ-1) ? '0 : IW'(idx + 1);
               slot           = slot + 1;
            end
         end
      end
   end

   assign stall = |(in_valid & ~grant);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr       <= '0;
         overflow_err <= 1'b0;
      end else begin
         rr_ptr <= rr_nxt;
         if (|ovf) overflow_err <= 1'b1;
      end
   end

   for (genvar q = 0; q < NUM_IQ; q++) begin : g_iq
      dispatch_credit_arbiter_iq #(.IQ_DEPTH(IQ_DEPTH), .CW(CW)) u_iq (
         .clk    (clk),
         .rst    (rst),
         .run    (run),
         .reload (reload),
         .alloc  (alloc[q]),
         .rel    (iq_release[q]),
         .credit (credit[q]),
         .ovf    (ovf[q])
      );
   end
endmodule

// File: tb/tb_dispatch_credit_arbiter.sv
module tb_dispatch_credit_arbiter;
   localparam int IN_WIDTH = 4;
   localparam int NUM_IQ   = 2;
   localparam int IQ_DEPTH = 8;
   localparam int CW       = 4;
   localparam int IW       = 1;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [IN_WIDTH-1:0]         in_valid;
   logic [NUM_IQ-1:0][CW-1:0]   iq_release;
   logic [NUM_IQ-1:0]           iq_empty;
   logic                        redirect;
   logic [IN_WIDTH-1:0]         grant;
   logic [IN_WIDTH-1:0][IW-1:0] grant_iq;
   logic                        stall;
   logic [NUM_IQ-1:0][CW-1:0]   credit;
   logic                        busy;
   logic                        overflow_err;

   always #5 clk = ~clk;

   dispatch_credit_arbiter #(.IN_WIDTH(IN_WIDTH), .NUM_IQ(NUM_IQ), .IQ_DEPTH(IQ_DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .iq_release   (iq_release),
      .iq_empty     (iq_empty),
      .redirect     (redirect),
      .grant        (grant),
      .grant_iq     (grant_iq),
      .stall        (stall),
      .credit       (credit),
      .busy         (busy),
      .overflow_err (overflow_err)
   );

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] iv, input logic [3:0] r0, input logic [3:0] r1,
                        input logic [1:0] emp, input logic redir);
      in_valid      = iv;
      iq_release[0] = r0;
      iq_release[1] = r1;
      iq_empty      = emp;
      redirect      = redir;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(4'b0, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic [3:0] iv;
      logic [3:0] r0, r1;
      logic [1:0] emp;
      logic       redir;
      logic [3:0] g;
      logic [3:0] giq;   // one IQ-index bit per slot
      logic       st;
      logic [3:0] c0, c1;
      logic       bsy, ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [3:0] iv, logic [3:0] r0, logic [3:0] r1, logic [1:0] emp,
                               logic redir, logic [3:0] g, logic [3:0] giq, logic st,
                               logic [3:0] c0, logic [3:0] c1, logic bsy, logic ovf);
      vec_t v;
      v.iv = iv; v.r0 = r0; v.r1 = r1; v.emp = emp; v.redir = redir;
      v.g = g; v.giq = giq; v.st = st; v.c0 = c0; v.c1 = c1; v.bsy = bsy; v.ovf = ovf;
      return v;
   endfunction

   task automatic check_regs(input logic [3:0] c0, input logic [3:0] c1, input logic bsy, input logic ovf);
      chk("credit0", credit[0], c0);
      chk("credit1", credit[1], c1);
      chk("busy", busy, bsy);
      chk("overflow_err", overflow_err, ovf);
   endtask

   // ---------------- reference model ----------------
   int mcred[NUM_IQ];
   int mocc[NUM_IQ];
   int mrr;
   bit mflush;
   bit movf;

   task automatic model_reset();
      for (int q = 0; q < NUM_IQ; q++) begin
         mcred[q] = IQ_DEPTH;
         mocc[q]  = 0;
      end
      mrr    = 0;
      mflush = 0;
      movf   = 0;
   endtask

   task automatic rand_cycle();
      logic [3:0] iv;
      logic [3:0] rel[NUM_IQ];
      logic [1:0] emp;
      logic       redir;
      int         elig[$];
      int         n, g, ng;
      logic [3:0] eg;
      bit         kill;

      redir = mflush ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
      iv    = 4'($urandom);
      for (int q = 0; q < NUM_IQ; q++)
         rel[q] = (!mflush && $urandom_range(0, 2) == 0) ? 4'($urandom_range(0, mocc[q])) : 4'd0;
      if (mflush) emp = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom);
      else        emp = 2'($urandom);
      drive(iv, rel[0], rel[1], emp, redir);

      // The grant prefix pairs the k-th valid slot with the k-th IQ holding credit.
      kill = mflush || redir;
      for (int k = 0; k < NUM_IQ; k++)
         if (mcred[(mrr + k) % NUM_IQ] > 0) elig.push_back((mrr + k) % NUM_IQ);
      n = 0;
      while (n < IN_WIDTH && iv[n]) n++;
      ng = elig.size();
      g  = kill ? 0 : ((n < ng) ? n : ng);
      eg = '0;
      for (int k = 0; k < g; k++) eg[k] = 1'b1;

      @(negedge clk);
      nvec++;
      chk("rnd_grant", grant, eg);
      chk("rnd_stall", stall, |(iv & ~eg));
      for (int k = 0; k < g; k++) chk("rnd_grant_iq", grant_iq[k], elig[k]);
      for (int k = 0; k < IN_WIDTH; k++)
         if (grant[k]) chk("rnd_grant_to_nonzero_credit", (credit[grant_iq[k]] != 0), 1);
      for (int q = 0; q < NUM_IQ; q++) begin
         chk("rnd_credit", credit[q], mcred[q]);
         chk("rnd_credit_plus_occ", credit[q] + mocc[q], IQ_DEPTH);
      end
      chk("rnd_busy", busy, mflush);
      chk("rnd_overflow_err", overflow_err, movf);

      for (int k = 0; k < g; k++) begin
         mcred[elig[k]]--;
         mocc[elig[k]]++;
      end
      if (g > 0) mrr = (elig[g-1] + 1) % NUM_IQ;
      if (!mflush) begin
         for (int q = 0; q < NUM_IQ; q++) begin
            mcred[q] += rel[q];
            mocc[q]  -= rel[q];
            if (mcred[q] > IQ_DEPTH) begin
               mcred[q] = IQ_DEPTH;
               movf     = 1;
            end
         end
         if (redir) mflush = 1;
      end else if (!redir && emp == 2'b11) begin
         mflush = 0;
         for (int q = 0; q < NUM_IQ; q++) begin
            mcred[q] = IQ_DEPTH;
            mocc[q]  = 0;
         end
      end
      tick();
   endtask

   initial begin
      //          iv       r0 r1 emp    rd  grant    giq      st  c0 c1 bsy ovf
      tbl.push_back(mk(4'b1111, 0, 0, 2'b00, 0, 4'b0011, 4'b0010, 1, 8, 8, 0, 0));
      tbl.push_back(mk(4'b0000, 0, 0, 2'b00, 0, 4'b0000, 4'b0000, 0, 7, 7, 0, 0));
      tbl.push_back(mk(4'b0010, 0, 0, 2'b00, 0, 4'b0000, 4'b0000, 1, 7, 7, 0, 0));
      tbl.push_back(mk(4'b0011, 0, 0, 2'b00, 0, 4'b0011, 4'b0010, 0, 7, 7, 0, 0));
      tbl.push_back(mk(4'b0011, 0, 0, 2'b00, 0, 4'b0011, 4'b0010, 0, 6, 6, 0, 0));
      tbl.push_back(mk(4'b0011, 0, 0, 2'b00, 0, 4'b0011, 4'b0010, 0, 5, 5, 0, 0));
      tbl.push_back(mk(4'b0011, 0, 0, 2'b00, 0, 4'b0011, 4'b0010, 0, 4, 4, 0, 0));
      tbl.push_back(mk(4'b0011, 0, 1, 2'b00, 0, 4'b0011, 4'b0010, 0, 3, 3, 0, 0));
      tbl.push_back(mk(4'b0011, 0, 1, 2'b00, 0, 4'b0011, 4'b0010, 0, 2, 3, 0, 0));
      tbl.push_back(mk(4'b0011, 0, 1, 2'b00, 0, 4'b0011, 4'b0010, 0, 1, 3, 0, 0));
      tbl.push_back(mk(4'b0011, 0, 0, 2'b00, 0, 4'b0001, 4'b0001, 1, 0, 3, 0, 0));
      tbl.push_back(mk(4'b0001, 1, 0, 2'b00, 0, 4'b0001, 4'b0001, 0, 0, 2, 0, 0));
      tbl.push_back(mk(4'b1111, 0, 0, 2'b00, 0, 4'b0011, 4'b0010, 1, 1, 1, 0, 0));
      tbl.push_back(mk(4'b0001, 8, 8, 2'b00, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0));
      tbl.push_back(mk(4'b0000, 1, 0, 2'b00, 0, 4'b0000, 4'b0000, 0, 8, 8, 0, 0));
      tbl.push_back(mk(4'b0001, 0, 0, 2'b00, 0, 4'b0001, 4'b0000, 0, 8, 8, 0, 1));
      tbl.push_back(mk(4'b0001, 0, 0, 2'b00, 0, 4'b0001, 4'b0001, 0, 7, 8, 0, 1));
      tbl.push_back(mk(4'b0011, 0, 0, 2'b00, 1, 4'b0000, 4'b0000, 1, 7, 7, 0, 1));
      tbl.push_back(mk(4'b0011, 1, 0, 2'b01, 0, 4'b0000, 4'b0000, 1, 7, 7, 1, 1));
      tbl.push_back(mk(4'b0011, 1, 0, 2'b01, 0, 4'b0000, 4'b0000, 1, 7, 7, 1, 1));
      tbl.push_back(mk(4'b0011, 1, 0, 2'b01, 0, 4'b0000, 4'b0000, 1, 7, 7, 1, 1));
      tbl.push_back(mk(4'b0011, 0, 0, 2'b11, 0, 4'b0000, 4'b0000, 1, 7, 7, 1, 1));
      tbl.push_back(mk(4'b0000, 0, 0, 2'b00, 0, 4'b0000, 4'b0000, 0, 8, 8, 0, 1));
      tbl.push_back(mk(4'b1111, 0, 0, 2'b00, 0, 4'b0011, 4'b0010, 1, 8, 8, 0, 1));

      do_reset();
      foreach (tbl[i]) begin
         drive(tbl[i].iv, tbl[i].r0, tbl[i].r1, tbl[i].emp, tbl[i].redir);
         @(negedge clk);
         nvec++;
         chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
         chk($sformatf("tbl%0d_stall", i), stall, tbl[i].st);
         for (int s = 0; s < IN_WIDTH; s++)
            if (tbl[i].g[s]) chk($sformatf("tbl%0d_grant_iq%0d", i, s), grant_iq[s], tbl[i].giq[s]);
         check_regs(tbl[i].c0, tbl[i].c1, tbl[i].bsy, tbl[i].ovf);
         tick();
      end

      // Redirect held while IQs are empty keeps FLUSH; reset in FLUSH ignores iq_empty.
      drive(4'b0011, 0, 0, 2'b00, 1'b1);   // RUN -> FLUSH, credits 7,7 after
      tick();
      drive(4'b0011, 0, 0, 2'b11, 1'b1);
      @(negedge clk);
      nvec++;
      chk("flush_hold_grant", grant, 4'b0000);
      check_regs(7, 7, 1, 1);
      tick();
      drive(4'b0000, 0, 0, 2'b00, 1'b0);
      @(negedge clk);
      nvec++;
      chk("flush_still_busy", busy, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(4'b0111, 0, 0, 2'b00, 1'b0);
      @(negedge clk);
      nvec++;
      check_regs(8, 8, 0, 0);
      chk("post_rst_grant", grant, 4'b0011);
      chk("post_rst_stall", stall, 1);
      tick();

      // Random run against the model
      do_reset();
      model_reset();
      for (int i = 0; i < 10000; i++) rand_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
